// File: rtl/uart_inst_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
package loader_pkg;

  // Loader FSM encoding.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Word that terminates a program load.
  localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Reference clock and line rate the default gap timeout is sized for.
  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BAUD    = 9_600;

  // One 10-bit UART frame at 9600 baud is ~52k cycles at 50 MHz;
  // 200k cycles (~4 ms) leaves margin for slow senders.
  localparam int unsigned GAP_CYCLES_DEFAULT = 200_000;

  // Place a byte into the little-endian lane selected by lane.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_inst_loader_gap_timer.sv
// Inter-byte gap timer: counts up from a load while enabled, saturates at
// the terminal count and flags expiry while enabled at that count.
module gap_timer #(
  parameter int unsigned GAP_CYCLES = 200_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load restarts from zero, otherwise count up and hold at TC.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !load_i && (cnt_q == TC);

endmodule

// File: rtl/uart_inst_loader.sv
// UART instruction loader: assembles little-endian 32-bit words from a byte
// stream and writes them to consecutive instruction-memory addresses until
// the terminator word arrives or memory is full.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_COLLECT | gathering bytes of the next word (byte_cnt = held bytes)
//   ST_WRITE   | full word held; write it, finish on terminator or full
//   ST_DONE    | load finished; only reset leaves this state
module uart_inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter logic [31:0] END_WORD   = END_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              write_done,
  output logic              overflow,
  output logic [1:0]        byte_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        rst_sync_q;
  logic              run;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       part_q, part_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic              tmr_load, tmr_en, tmr_expired;

  // Reset release is synchronised; assertion still clears everything at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  assign tmr_load = run && (state_q != ST_DONE) && (uart_rx_valid || uart_rx_break);
  assign tmr_en   = run && (state_q == ST_COLLECT) && (cnt_q != 2'd0);

  gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  // Next-state and write-strobe logic; everything holds until run is set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    data_d  = data_q;
    addr_d  = addr_q;
    full_d  = full_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (run) begin
      case (state_q)
        ST_COLLECT: begin
          if (uart_rx_break) begin
            cnt_d  = 2'd0;
            part_d = '0;
          end else if (uart_rx_valid) begin
            if (cnt_q == 2'd3) begin
              data_d  = insert_byte(part_q, cnt_q, uart_rx_data);
              part_d  = '0;
              cnt_d   = 2'd0;
              state_d = ST_WRITE;
            end else begin
              part_d = insert_byte(part_q, cnt_q, uart_rx_data);
              cnt_d  = cnt_q + 2'd1;
            end
          end else if (tmr_expired) begin
            cnt_d  = 2'd0;
            part_d = '0;
          end
        end
        ST_WRITE: begin
          state_d = ST_COLLECT;
          if (data_q == END_WORD) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (full_q) begin
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_en = 1'b1;
            if (addr_q == LAST_ADDR) begin
              full_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
          // A byte landing during the write starts the next word.
          if ((state_d == ST_COLLECT) && uart_rx_valid && !uart_rx_break) begin
            part_d = {24'h0, uart_rx_data};
            cnt_d  = 2'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_COLLECT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_COLLECT;
      cnt_q   <= 2'd0;
      part_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign imem_wr_en   = wr_en;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = data_q;
  assign write_done   = done_q;
  assign overflow     = ovf_q;
  assign byte_cnt     = cnt_q;

endmodule
